// File: rtl/inst_fetch_bridge.sv
// ============================================================================
// inst_fetch_bridge
//
// Connects the CPU core's instruction-fetch port to a slower external
// instruction memory. The memory uses a req/ack handshake with variable
// latency.
//
// A one-entry fetch buffer serves repeat fetches of the same word with zero
// added latency. On a miss the bridge raises stall_req_o and issues a single
// memory request. Pipeline control uses stall_req_o to hold pc_reg and if_id
// until the word arrives.
//
// If the memory reports an error, or does not answer within TIMEOUT cycles,
// the buffer is filled with NOP_WORD and the sticky err_o flag is raised.
// This guarantees the core always makes forward progress.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   cpu_ce_i     fetch enable from core (rom_ce_o)
//   cpu_addr_i   fetch address from core (rom_addr_o), byte address
//   cpu_data_o   instruction to core (rom_data_i)
//   stall_req_o  fetch not yet satisfied, core must hold its PC
//   flush_i      invalidate buffer and drop any in-flight response
//   mem_req_o    request to external memory, held until ack or timeout
//   mem_addr_o   word-aligned request address, stable while mem_req_o=1
//   mem_ack_i    one-cycle response strobe
//   mem_rdata_i  response data, valid with mem_ack_i
//   mem_err_i    response error, valid with mem_ack_i
//   err_o        sticky: an error or timeout has occurred since reset
// ============================================================================
module inst_fetch_bridge #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stall_req_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i,
  output logic              err_o
);

  // The wait counter is sized for the largest supported TIMEOUT (65535).
  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] fetch_addr;
  logic              addr_lsb_unused;

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic [CNT_W-1:0]  wait_cnt;
  logic              discard_q;

  logic              hit;
  logic              issue;
  logic              finish;
  logic              failed;
  logic              fill;

  // Instructions are word-aligned, so the byte-offset bits of the fetch
  // address never take part in matching or in the memory address.
  assign fetch_addr      = {cpu_addr_i[ADDR_W-1:2], 2'b00};
  assign addr_lsb_unused = ^cpu_addr_i[1:0];

  // Hit and stall are purely combinational. A miss therefore stalls the core
  // in the same cycle the fetch is presented.
  assign hit         = cpu_ce_i & buf_valid & (fetch_addr == buf_addr);
  assign stall_req_o = cpu_ce_i & ~hit & ~flush_i;

  // Return buffered data on a hit and zero when the core is not fetching.
  // A miss shows NOP_WORD so a stalled pipeline never sees stale data.
  always_comb begin
    cpu_data_o = NOP_WORD;
    if (hit) begin
      cpu_data_o = buf_data;
    end else if (!cpu_ce_i) begin
      cpu_data_o = '0;
    end
  end

  // Next-state logic. "finish" marks the edge on which the single outstanding
  // request ends. The request ends on an ack, or when the wait counter reaches
  // its last value. "failed" says whether the result is a NOP fill.
  // A new request can only start from IDLE, and the FSM only leaves REQ on
  // "finish". So no request is ever issued on the edge that accepts an ack.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    finish  = 1'b0;
    failed  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !hit && !flush_i) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          finish  = 1'b1;
          failed  = mem_err_i;
          state_d = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          finish  = 1'b1;
          failed  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completed request only lands in the buffer when it was not flushed.
  // A flush counts whether it arrived earlier in the request (discard_q) or
  // on the same edge as the ack; in both cases the flush wins.
  assign fill = finish & ~discard_q & ~flush_i;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory request side. mem_req_o and mem_addr_o are registered so they
  // stay glitch-free and stable for the whole request. mem_addr_o keeps the
  // last request address after the request ends. The wait counter restarts
  // on issue and then counts every REQ cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      wait_cnt   <= '0;
    end else if (issue) begin
      mem_req_o  <= 1'b1;
      mem_addr_o <= fetch_addr;
      wait_cnt   <= '0;
    end else if (finish) begin
      mem_req_o  <= 1'b0;
      wait_cnt   <= '0;
    end else if (state_q == REQ) begin
      wait_cnt   <= wait_cnt + 1'b1;
    end
  end

  // One-entry fetch buffer. A flush invalidates it unconditionally. Error and
  // timeout fills still mark the entry valid, so the core can take the NOP and
  // move on instead of re-requesting a word the memory cannot supply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      if (flush_i) begin
        buf_valid <= 1'b0;
      end else if (fill) begin
        buf_valid <= 1'b1;
      end
      if (fill) begin
        buf_addr <= mem_addr_o;
        buf_data <= failed ? NOP_WORD : mem_rdata_i;
      end
    end
  end

  // A flush during an outstanding request cannot cancel the memory
  // handshake. Instead it arms the discard flag so the eventual response is
  // dropped. The flag clears when that request ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard_q <= 1'b0;
    end else if (finish) begin
      discard_q <= 1'b0;
    end else if (flush_i && state_q == REQ) begin
      discard_q <= 1'b1;
    end
  end

  // The error flag is sticky until reset. It is raised even when the
  // response itself was discarded by a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (finish && failed) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// ============================================================================
// tb_inst_fetch_bridge
//
// Self-checking bench for inst_fetch_bridge (TIMEOUT=8, NOP_WORD=0x13).
// The bench runs four kinds of stimulus:
//   - a directed vector table covering fill, alignment hit, error fill and a
//     sticky error;
//   - hand-written sequences for timeout, flush discard and async reset in
//     the middle of a request;
//   - a randomized run with a small memory responder;
//   - a reference model of the fetch buffer driven by the random run.
// ============================================================================
module tb_inst_fetch_bridge;

  localparam int          TIMEOUT = 8;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          NUM_VEC = 14;
  localparam int          NUM_RND = 1500;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stall_req_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        err_o;

  int checkCount = 0;
  int errorCount = 0;

  inst_fetch_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT),
    .NOP_WORD(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_o (cpu_data_o),
    .stall_req_o(stall_req_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_err_i  (mem_err_i),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded loops.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One row per clock cycle: the inputs driven in that cycle and the
  // outputs expected at the falling edge of the same cycle.
  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        merr;
    logic [31:0] expData;
    logic        expStall;
    logic        expReq;
    logic [31:0] expMaddr;
    logic        expErr;
  } vec_t;

  vec_t vecs[NUM_VEC];

  // Reference model state for the random run.
  logic        mValid;
  logic [31:0] mBufAddr;
  logic [31:0] mBufData;
  logic        mBusy;
  logic [31:0] mReqAddr;
  int          mAge;
  logic        mDiscard;
  logic        mErr;

  // Memory responder state for the random run.
  logic        inSvc;
  int          svcLat;
  int          svcCnt;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] alignAddr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic [31:0] addr,
                               input logic flush, input logic ack,
                               input logic [31:0] rdata, input logic merr);
    cpu_ce_i    = ce;
    cpu_addr_i  = addr;
    flush_i     = flush;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    mem_err_i   = merr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle, wait for the falling edge, and check all five outputs.
  task automatic stepCheck(input string tag, input logic ce,
                           input logic [31:0] addr, input logic flush,
                           input logic ack, input logic [31:0] rdata,
                           input logic merr, input logic [31:0] expData,
                           input logic expStall, input logic expReq,
                           input logic [31:0] expMaddr, input logic expErr);
    nextCycle();
    applyStimulus(ce, addr, flush, ack, rdata, merr);
    @(negedge clk);
    checkOutput({tag, "_data"},  cpu_data_o,         expData);
    checkOutput({tag, "_stall"}, {31'b0, stall_req_o}, {31'b0, expStall});
    checkOutput({tag, "_req"},   {31'b0, mem_req_o},   {31'b0, expReq});
    checkOutput({tag, "_maddr"}, mem_addr_o,         expMaddr);
    checkOutput({tag, "_err"},   {31'b0, err_o},       {31'b0, expErr});
  endtask

  // Random-run reference: predict this cycle's outputs from the fetch-buffer
  // rules, compare them, then advance the model by one clock using the
  // inputs of this cycle.
  task automatic modelStep();
    logic        pHit;
    logic [31:0] pData;
    logic        pStall;
    logic        ends;
    logic        good;
    pHit   = cpu_ce_i && mValid && (alignAddr(cpu_addr_i) == mBufAddr);
    pData  = pHit ? mBufData : (cpu_ce_i ? NOP : 32'h0);
    pStall = cpu_ce_i && !pHit && !flush_i;
    checkOutput("rnd_data",  cpu_data_o,           pData);
    checkOutput("rnd_stall", {31'b0, stall_req_o}, {31'b0, pStall});
    checkOutput("rnd_req",   {31'b0, mem_req_o},   {31'b0, mBusy});
    checkOutput("rnd_maddr", mem_addr_o,           mReqAddr);
    checkOutput("rnd_err",   {31'b0, err_o},       {31'b0, mErr});
    if (mBusy) begin
      mAge++;
      ends = mem_ack_i || (mAge == TIMEOUT);
      good = mem_ack_i && !mem_err_i;
      if (ends) begin
        mBusy = 1'b0;
        if (!good) mErr = 1'b1;
        if (!mDiscard && !flush_i) begin
          mValid   = 1'b1;
          mBufAddr = mReqAddr;
          mBufData = good ? memWord(mReqAddr) : NOP;
        end
        mDiscard = 1'b0;
      end else if (flush_i) begin
        mDiscard = 1'b1;
      end
    end else if (pStall) begin
      mBusy    = 1'b1;
      mReqAddr = alignAddr(cpu_addr_i);
      mAge     = 0;
    end
    if (flush_i) mValid = 1'b0;
  endtask

  initial begin
    int          reqCycles;
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        merr;

    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // ce, addr, flush, ack, rdata, merr | data, stall, req, maddr, err
    vecs[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b1, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b1, 1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b1, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h3401_1100, 1'b0, NOP,           1'b1, 1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h3401_1100, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h2, 1'b0, 1'b0, 32'h0,         1'b0, 32'h3401_1100, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h2, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b1, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h4, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, NOP,           1'b1, 1'b1, 32'h4, 1'b0};
    vecs[9]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b0, 1'b0, 32'h4, 1'b1};
    vecs[10] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, NOP,           1'b1, 1'b0, 32'h4, 1'b1};
    vecs[11] = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h3401_1100, 1'b0, NOP,           1'b1, 1'b1, 32'h0, 1'b1};
    vecs[12] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h3401_1100, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 32'h1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h3401_1100, 1'b0, 1'b0, 32'h0, 1'b1};

    // Reset state.
    doReset();
    checkOutput("rst_data",  cpu_data_o,           32'h0);
    checkOutput("rst_stall", {31'b0, stall_req_o}, 32'h0);
    checkOutput("rst_req",   {31'b0, mem_req_o},   32'h0);
    checkOutput("rst_maddr", mem_addr_o,           32'h0);
    checkOutput("rst_err",   {31'b0, err_o},       32'h0);

    // Directed vector table.
    for (int i = 0; i < NUM_VEC; i++) begin
      stepCheck($sformatf("vec%0d", i), vecs[i].ce, vecs[i].addr,
                vecs[i].flush, vecs[i].ack, vecs[i].rdata, vecs[i].merr,
                vecs[i].expData, vecs[i].expStall, vecs[i].expReq,
                vecs[i].expMaddr, vecs[i].expErr);
    end

    // Timeout: memory never acks, so the request lasts exactly TIMEOUT cycles.
    $display("[TB] timeout sequence");
    doReset();
    stepCheck("to_miss", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    reqCycles = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (mem_req_o) reqCycles++;
      else if (reqCycles > 0) break;
    end
    checkOutput("to_req_cycles", reqCycles, TIMEOUT);
    checkOutput("to_fill_data",  cpu_data_o,           NOP);
    checkOutput("to_fill_stall", {31'b0, stall_req_o}, 32'h0);
    checkOutput("to_fill_err",   {31'b0, err_o},       32'h1);
    stepCheck("to_late_ack", 1'b1, 32'h100, 1'b0, 1'b1, 32'h1234_5678, 1'b0,
              NOP, 1'b0, 1'b0, 32'h100, 1'b1);
    stepCheck("to_after", 1'b1, 32'h101, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b0, 1'b0, 32'h100, 1'b1);

    // Flush in the second REQ cycle: the response is dropped and refetched.
    $display("[TB] flush sequence");
    doReset();
    stepCheck("fl_miss", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    stepCheck("fl_req1", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b1, 32'h8, 1'b0);
    stepCheck("fl_req2", 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0,
              NOP, 1'b0, 1'b1, 32'h8, 1'b0);
    stepCheck("fl_ack", 1'b1, 32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0,
              NOP, 1'b1, 1'b1, 32'h8, 1'b0);
    stepCheck("fl_remiss", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b0, 32'h8, 1'b0);
    stepCheck("fl_rereq", 1'b1, 32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0,
              NOP, 1'b1, 1'b1, 32'h8, 1'b0);
    stepCheck("fl_hit", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0,
              32'hDEAD_BEEF, 1'b0, 1'b0, 32'h8, 1'b0);

    // Async reset in the middle of a request.
    $display("[TB] async reset sequence");
    stepCheck("ar_miss", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b0, 32'h8, 1'b0);
    stepCheck("ar_errack", 1'b1, 32'h20, 1'b0, 1'b1, 32'h5555_5555, 1'b1,
              NOP, 1'b1, 1'b1, 32'h20, 1'b0);
    stepCheck("ar_nopfill", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b0, 1'b0, 32'h20, 1'b1);
    stepCheck("ar_miss2", 1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b0, 32'h20, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("ar_req_before", {31'b0, mem_req_o}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("ar_req_in_rst", {31'b0, mem_req_o}, 32'h0);
    checkOutput("ar_err_in_rst", {31'b0, err_o},     32'h0);
    cpu_addr_i = 32'h20;
    #1;
    checkOutput("ar_valid_in_rst", {31'b0, stall_req_o}, 32'h1);
    cpu_addr_i = 32'h24;
    @(negedge clk);
    rst = 1'b1;
    stepCheck("ar_fresh_req", 1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0,
              NOP, 1'b1, 1'b1, 32'h24, 1'b0);

    // Randomized run against the reference model.
    $display("[TB] random sequence");
    doReset();
    mValid   = 1'b0;
    mBufAddr = 32'h0;
    mBufData = 32'h0;
    mBusy    = 1'b0;
    mReqAddr = 32'h0;
    mAge     = 0;
    mDiscard = 1'b0;
    mErr     = 1'b0;
    inSvc    = 1'b0;
    svcLat   = 0;
    svcCnt   = 0;
    for (int i = 0; i < NUM_RND; i++) begin
      nextCycle();
      ce    = ($urandom % 5) != 0;
      addr  = ($urandom_range(0, 5) << 2) | ($urandom & 32'h3);
      flush = ($urandom % 16) == 0;
      if (mem_req_o) begin
        if (!inSvc) begin
          inSvc  = 1'b1;
          svcLat = $urandom_range(1, 10);
          svcCnt = 0;
        end
        svcCnt++;
        ack   = (svcCnt == svcLat);
        rdata = ack ? memWord(mem_addr_o) : $urandom;
        merr  = ack && (($urandom % 6) == 0);
      end else begin
        inSvc = 1'b0;
        ack   = ($urandom % 8) == 0;
        rdata = $urandom;
        merr  = $urandom_range(0, 1) == 1;
      end
      applyStimulus(ce, addr, flush, ack, rdata, merr);
      @(negedge clk);
      modelStep();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
